// File: rtl/input_buffer_pkg.sv
// Shared constants and helpers for the line-sensor input conditioning block.
package input_buffer_pkg;

  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1;

  // Debounce counter width: enough bits to hold 0..n. A bypassed filter
  // still gets 1 bit so declarations stay legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_sync_channel.sv
// One sensor channel: multi-flop synchronizer followed by an optional
// debounce filter that only passes levels held for DEBOUNCE_CYCLES edges.
module sensor_sync_channel
  import input_buffer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  // Bit 0 is the only flop allowed to go metastable; only bit 1 reads it.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  // Synchronizer shift chain, stage 0 samples the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 1) begin : g_bypass
    assign dout = sync;
  end else begin : g_debounce
    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    // Count consecutive edges where sync disagrees with the output; any
    // agreement restarts the count, the Nth disagreement commits the level.
    always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      if (sync == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        out_d = sync;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
      end
    end

    assign dout = out_q;
  end

endmodule

// File: rtl/input_buffer.sv
// Conditions the three raw line-sensor pins (left/centre/right) into
// clock-domain-safe, optionally debounced levels for the steering logic.
module input_buffer
  import input_buffer_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic a_out,
  output logic b_out,
  output logic c_out
);

  localparam int NUM_CH = 3;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_buffer: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
    $error("input_buffer: DEBOUNCE_CYCLES=%0d outside 1..255", DEBOUNCE_CYCLES);
  end

  logic [NUM_CH-1:0] din, dout;

  assign din = {c, b, a};

  // Channels are fully independent: one identical instance per sensor.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_sync_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (din[i]),
      .dout (dout[i])
    );
  end

  assign {c_out, b_out, a_out} = dout;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed scenarios on a bypass instance (N=1) and
// a debounce instance (N=4) sharing the same pins, plus a random run scored
// against a sample-history model.
module tb_input_buffer;

  localparam int S  = 2;
  localparam int N4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic a1, b1, c1, a4, b4, c4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_buffer dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .a_out(a1), .b_out(b1), .c_out(c1)
  );

  input_buffer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .a_out(a4), .b_out(b4), .c_out(c4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 1'b1; b = 1'b1; c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({a1, b1, c1, a4, b4, c4} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b want 000000", i, {a1, b1, c1, a4, b4, c4});
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_chk++;
    if ({a1, b1, c1, a4, b4, c4} !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_rise: got %b want 111111", {a1, b1, c1, a4, b4, c4});
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a1, b1, c1, a4, b4, c4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 000000", {a1, b1, c1, a4, b4, c4});
    end
  endtask

  task automatic test_latency();
    do_reset();
    a = 1'b0; b = 1'b1; c = 1'b0;
    tick();
    n_chk++;
    if ({a1, b1, c1} !== 3'b000) begin
      n_fail++;
      $display("FAIL latency_e1: got %b want 000", {a1, b1, c1});
    end
    tick();
    n_chk++;
    if ({a1, b1, c1} !== 3'b010) begin
      n_fail++;
      $display("FAIL latency_e2: got %b want 010", {a1, b1, c1});
    end
  endtask

  task automatic test_short_pulse();
    logic [3:0] exp_a;
    do_reset();
    exp_a = 4'b0110;  // a_out after edges 1..4 (bit 3 = edge 1)
    a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) a = 1'b0;
      n_chk++;
      if ({a1, b1, c1} !== {exp_a[3-i], 2'b00}) begin
        n_fail++;
        $display("FAIL short_pulse e%0d: got %b want %b", i + 1, {a1, b1, c1}, {exp_a[3-i], 2'b00});
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a = 1'b1; b = 1'b1; c = 1'b0;
    tick();
    tick();
    a = 1'b0; b = 1'b0; c = 1'b1;
    tick();
    n_chk++;
    if ({a1, b1, c1} !== 3'b110) begin
      n_fail++;
      $display("FAIL simul_e1: got %b want 110", {a1, b1, c1});
    end
    tick();
    n_chk++;
    if ({a1, b1, c1} !== 3'b001) begin
      n_fail++;
      $display("FAIL simul_e2: got %b want 001", {a1, b1, c1});
    end
  endtask

  task automatic test_debounce();
    do_reset();
    c = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_chk++;
      if (c4 !== 1'b0) begin
        n_fail++;
        $display("FAIL debounce_glitch e%0d: got %b want 0", i, c4);
      end
    end
    c = 1'b1;
    for (int i = 1; i <= S + N4; i++) begin
      tick();
      n_chk++;
      if (c4 !== (i == S + N4)) begin
        n_fail++;
        $display("FAIL debounce_hold e%0d: got %b want %b", i, c4, (i == S + N4));
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    c = 1'b1;
    for (int i = 0; i < 4; i++) tick();  // counter now at 2
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a4, b4, c4, c1} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want 0000", {a4, b4, c4, c1});
    end
    #1 rst_n = 1'b1;
    for (int i = 1; i <= S + N4; i++) begin
      tick();
      n_chk++;
      if (c4 !== (i == S + N4)) begin
        n_fail++;
        $display("FAIL mid_reset_refill e%0d: got %b want %b", i, c4, (i == S + N4));
      end
    end
  endtask

  // Model: out(N=1) is the pin sample from S-1 edges ago; out(N=4) flips
  // when the last N pre-edge synchronized values all disagree with it.
  task automatic test_random();
    logic [2:0] hist[$];
    logic [2:0] m4, exp1;
    logic       flip;
    do_reset();
    hist = {};
    for (int i = 0; i < 16; i++) hist.push_back(3'b000);
    m4 = 3'b000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(3) == 0) a = ~a;
      if ($urandom_range(5) == 0) b = ~b;
      if ($urandom_range(9) == 0) c = ~c;
      @(posedge clk);
      for (int ch = 0; ch < 3; ch++) begin
        flip = 1'b1;
        for (int k = 1; k <= N4; k++)
          if (hist[S-2+k][ch] == m4[ch]) flip = 1'b0;
        if (flip) m4[ch] = ~m4[ch];
      end
      hist.push_front({c, b, a});
      void'(hist.pop_back());
      exp1 = hist[S-1];
      #1;
      n_chk++;
      if ({c1, b1, a1} !== exp1) begin
        n_fail++;
        $display("FAIL random_n1 cyc%0d: got %b want %b", cyc, {c1, b1, a1}, exp1);
      end
      n_chk++;
      if ({c4, b4, a4} !== m4) begin
        n_fail++;
        $display("FAIL random_n4 cyc%0d: got %b want %b", cyc, {c4, b4, a4}, m4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_pulse();
    test_simultaneous();
    test_debounce();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
Name: input_buffer

Overview:
- Input conditioning for the line-follower's three reflective line sensors (left/centre/right: a, b, c).
- Each raw, asynchronous sensor level passes through a multi-flop synchronizer, then an optional per-channel debounce filter.
- The clean, clock-domain-safe outputs (a_out, b_out, c_out) feed the steering/control logic.
- Sits directly behind the top-level sensor pins.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 1, consecutive clock cycles a new synchronized level must persist before the output takes it; legal range 1..255; 1 = filter bypassed.

Ports:
- clk  input  1  system clock, 100 MHz nominal; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  raw sensor A level, asynchronous to clk.
- b  input  1  raw sensor B level, asynchronous to clk.
- c  input  1  raw sensor C level, asynchronous to clk.
- a_out  output  1  conditioned sensor A.
- b_out  output  1  conditioned sensor B.
- c_out  output  1  conditioned sensor C.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0): immediately, without waiting for a clock edge, clears all synchronizer flops, debounce counters and output registers to 0, so a_out=b_out=c_out=0.
- Reset release: deassertion is synchronous in effect; the first clk edge with rst_n=1 samples the inputs.
- Channels are identical and fully independent; no cross-channel logic.
- Synchronizer: a shift chain of SYNC_STAGES flops; stage 0 samples the raw input. sync = last stage.
- DEBOUNCE_CYCLES=1:
  - out = sync directly, no extra register.
  - Latency is exactly SYNC_STAGES rising edges from the first edge that samples the new level.
  - Default case: input changes at t=10 ns, edges at 5/15/25 ns; stage 0 captures at 15 ns; out changes at 25 ns.
- DEBOUNCE_CYCLES=N≥2:
  - Per-channel counter, width clog2(N+1), plus a registered out.
  - Each edge, if sync==out: counter cleared to 0.
  - Else, if counter==N-1: out<=sync and counter cleared to 0.
  - Else: counter incremented.
  - A new level therefore reaches out on the Nth consecutive edge at which sync differs from out. Latency = SYNC_STAGES+N edges.
  - A glitch shorter than N cycles at sync is fully suppressed; counter restarts from 0 on any reversion.
- Pulse width: with N=1, any input level held ≥1 clock period and spanning a rising edge propagates. Example: a 20 ns pulse yields a 2-cycle a_out pulse.
- Reset mid-operation: counters and the synchronizer chain are discarded; outputs return to 0 at once.
- Metastability: only stage 0 may go metastable; no logic other than stage 1 reads stage 0.
- No combinational path from a/b/c to the outputs.

Decomposition:
- Package input_buffer_pkg:
  - SYNC_STAGES_DEFAULT=2, DEBOUNCE_CYCLES_DEFAULT=1.
  - Function computing the counter width from DEBOUNCE_CYCLES.
- Sub-module sensor_sync_channel: clk, rst_n, din, dout, same two parameters. Implements one synchronizer chain plus filter.
- input_buffer instantiates sensor_sync_channel three times (a, b, c). Add elaboration-time assertions on the parameter ranges.

Test Plan:
- Reset: hold rst_n=0 with a=b=c=1 for 3 cycles -> a_out=b_out=c_out=0 throughout. Assert rst_n=0 between edges while outputs are 1 -> outputs drop to 0 before the next edge.
- Default latency: after reset, a=0, b=1, c=0 at t=0 -> b_out=1 at the 2nd rising edge after sampling, a_out=c_out=0.
- Short pulse: raise a at t=10 ns, lower at t=30 ns (edges 5/15/25/35 ns) -> a_out=1 from 25 ns to 45 ns, exactly 2 cycles. b and c unaffected until their own change.
- Simultaneous change: at t=30 ns set a=0, b=0, c=1 -> all three outputs update on the same edge (45 ns), no intermediate mixed state.
- Debounce (DEBOUNCE_CYCLES=4): apply a 3-cycle high pulse on c -> c_out stays 0. Apply a 4-cycle or longer high -> c_out=1 exactly 2+4 edges after the first sampling edge.
- Async reset mid-debounce (N=4): pulse rst_n low while the counter is at 2 -> c_out=0 at once. After release, a stable c=1 needs the full 2+4 edges again.
